// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks.
package serial_arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Bit-counter width for a WIDTH-bit serial operation; never narrower than one bit.
    function automatic int unsigned count_width(input int unsigned width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/behavioralFullAdder.sv
// Single-bit full-adder cell stepped by the serial adder sequencer.
module behavioralFullAdder (
    output logic sum,
    output logic carryout,
    input  logic a,
    input  logic b,
    input  logic carryin
);

    // Two-bit result of the one-bit add: {carry, sum}.
    always_comb begin
        {carryout, sum} = {1'b0, a} + {1'b0, b} + {1'b0, carryin};
    end

endmodule

// File: rtl/bit_serial_adder.sv
// Multi-cycle adder: feeds one operand bit pair per cycle, LSB first, through a single
// full-adder cell and presents sum, carry-out and signed overflow through valid/ready.
module bit_serial_adder
    import serial_arith_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int unsigned CW = count_width(WIDTH);
    localparam logic [CW-1:0] LastBit = CW'(WIDTH - 1);

    state_e           state_q;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic             carry_q;
    logic [CW-1:0]    count_q;
    // Partial result holds the WIDTH-1 earlier bits; the final bit joins at completion.
    logic [WIDTH-2:0] res_sh_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;

    logic             fa_sum;
    logic             fa_cout;
    logic [WIDTH-1:0] res_next;

    behavioralFullAdder u_fa (
        .sum      (fa_sum),
        .carryout (fa_cout),
        .a        (a_sh_q[0]),
        .b        (b_sh_q[0]),
        .carryin  (carry_q)
    );

    // New sum bit enters at the MSB so that after WIDTH shifts bit 0 lands at index 0.
    always_comb begin
        res_next = {fa_sum, res_sh_q};
    end

    // Sequencer: operand load, per-bit shift/carry update, result capture and handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            carry_q  <= 1'b0;
            count_q  <= '0;
            res_sh_q <= '0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_sh_q  <= a;
                        b_sh_q  <= b;
                        carry_q <= cin;
                        count_q <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    a_sh_q   <= a_sh_q >> 1;
                    b_sh_q   <= b_sh_q >> 1;
                    carry_q  <= fa_cout;
                    res_sh_q <= res_next[WIDTH-1:1];
                    if (count_q == LastBit) begin
                        // carry_q is still the carry into the MSB at this point.
                        sum_q   <= res_next;
                        cout_q  <= fa_cout;
                        ovf_q   <= carry_q ^ fa_cout;
                        state_q <= DONE;
                    end else begin
                        count_q <= count_q + CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Handshake flags decode from state only; result outputs come straight from flops.
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        sum       = sum_q;
        cout      = cout_q;
        overflow  = ovf_q;
    end

endmodule

// File: tb/tb_bit_serial_adder.sv
// Self-checking bench for bit_serial_adder (WIDTH = 8).
module tb_bit_serial_adder;

    localparam int W = 8;

    logic         clk;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         overflow;

    int n_checks = 0;
    int n_errors = 0;

    bit_serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: unsigned sum with carry, and signed range test for overflow.
    task automatic model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv,
                         output logic [W-1:0] s, output logic c, output logic ov);
        int unsigned u;
        int          sg;
        u  = int'(av) + int'(bv) + int'(cv);
        sg = int'($signed(av)) + int'($signed(bv)) + int'(cv);
        s  = u[W-1:0];
        c  = (u >= (1 << W));
        ov = (sg > 127) || (sg < -128);
    endtask

    // One full transaction; called with time just after a rising edge and the DUT idle.
    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv,
                          input int stall, input bit inject);
        logic [W-1:0] es;
        logic         ec;
        logic         eo;
        int           lat;
        model(av, bv, cv, es, ec, eo);
        check("idle_in_ready", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        a = av;
        b = bv;
        cin = cv;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            check("run_in_ready", {31'd0, in_ready}, 32'd0);
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", lat, W);
        check("sum", {24'd0, sum}, {24'd0, es});
        check("cout", {31'd0, cout}, {31'd0, ec});
        check("overflow", {31'd0, overflow}, {31'd0, eo});
        for (int i = 0; i < stall; i++) begin
            if (inject) begin
                in_valid = 1'b1;
                a = 8'h11;
                b = W'($urandom);
            end
            @(posedge clk);
            #1;
            check("stall_valid", {31'd0, out_valid}, 32'd1);
            check("stall_in_ready", {31'd0, in_ready}, 32'd0);
            check("stall_sum", {23'd0, cout, sum}, {23'd0, ec, es});
            check("stall_ovf", {31'd0, overflow}, {31'd0, eo});
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("post_in_ready", {31'd0, in_ready}, 32'd1);
        check("post_out_valid", {31'd0, out_valid}, 32'd0);
        check("post_held", {23'd0, cout, sum}, {23'd0, ec, es});
    endtask

    initial begin
        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = '0;
        b = '0;
        cin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_sum", {24'd0, sum}, 32'd0);
        check("rst_cout", {31'd0, cout}, 32'd0);
        check("rst_ovf", {31'd0, overflow}, 32'd0);

        // Directed cases
        run_op(8'h05, 8'h03, 1'b0, 0, 1'b0);
        run_op(8'hFF, 8'h01, 1'b0, 1, 1'b0);
        run_op(8'h7F, 8'h01, 1'b0, 0, 1'b0);
        run_op(8'h80, 8'h80, 1'b0, 2, 1'b0);
        run_op(8'hFF, 8'hFF, 1'b1, 5, 1'b1);

        // Reset pulse during the third RUN cycle discards the operation.
        in_valid = 1'b1;
        a = 8'h55;
        b = 8'h66;
        cin = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_result", {22'd0, overflow, cout, sum}, 32'd0);
        run_op(8'h10, 8'h20, 1'b0, 0, 1'b0);

        // Randomized operands with random output stalls
        for (int n = 0; n < 1000; n++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)),
                   1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
